// File: rtl/instr_issuer_pkg.sv
// Shared types and instruction field positions for the instruction issuer.
package instr_issuer_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, ACK, EXEC} state_t;

    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 13;
    localparam int ALU_HI  = 12;
    localparam int ALU_LO  = 11;
    localparam int SH_HI   = 4;
    localparam int SH_LO   = 3;

endpackage

// File: rtl/issue_fifo.sv
// Small synchronous FIFO holding queued instructions; extra pointer bit
// distinguishes full from empty.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A flush wins over both push and pop in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_issuer.sv
// Issues buffered instructions to the controller over the start/waiting
// handshake and holds decode fields stable until the instruction retires.
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    input  logic               flush,
    input  logic               waiting,
    output logic               start,
    output logic [2:0]         opcode,
    output logic [1:0]         ALU_op,
    output logic [1:0]         shift_op,
    output logic [15:0]        cur_instr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   retired,
    output logic               ack_err
);

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [INSTR_W-1:0]   cur;
    logic [INSTR_W-1:0]   head;
    logic [ACK_W-1:0]     ackcnt;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 ack_last;

    issue_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .flush (flush),
        .din   (in_instr),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign ack_last = (ackcnt == ACK_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && waiting && !flush) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                start     = 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                if (!waiting)      state_nxt = EXEC;
                else if (ack_last) state_nxt = IDLE;
            end
            EXEC: begin
                if (waiting) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            ackcnt  <= '0;
            ack_err <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (pop) cur <= head;
            if (state == ISSUE)
                ackcnt <= '0;
            else if (state == ACK && waiting)
                ackcnt <= ackcnt + 1'b1;
            // Controller never dropped waiting: drop the instruction, flag it.
            if (state == ACK && waiting && ack_last) ack_err <= 1'b1;
            if (done) retired <= retired + 1'b1;
        end
    end

    assign in_ready  = !full;
    assign busy      = (state != IDLE);
    assign cur_instr = cur;
    assign opcode    = cur[OP_HI:OP_LO];
    assign ALU_op    = cur[ALU_HI:ALU_LO];
    assign shift_op  = cur[SH_HI:SH_LO];

endmodule

// File: doc/instr_issuer.md
Name: instr_issuer

Overview:
- Producer end of the controller's start/waiting handshake.
- Buffers 16-bit instructions from an upstream source in a small FIFO.
- Presents one instruction's decode fields (opcode, ALU_op, shift_op) to the controller, pulses start, and tracks the controller through acknowledge and completion.
- Holds the fields stable for the whole execution, then retires the instruction and issues the next.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
ACK_TIMEOUT, 8, cycles allowed for waiting to fall after start
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_instr  in  16  upstream instruction {op[15:13],alu[12:11],Rn[10:8],Rd[7:5],sh[4:3],Rm[2:0]}
in_ready  out  1  FIFO can accept (= not full)
flush  in  1  synchronous: discard all queued FIFO entries
waiting  in  1  controller idle indicator
start  out  1  one-cycle issue pulse to controller
opcode  out  3  cur[15:13]
ALU_op  out  2  cur[12:11]
shift_op  out  2  cur[4:3]
cur_instr  out  16  full held instruction for datapath register fields
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when an instruction retires
retired  out  CNT_W  retired count, wraps modulo 2^CNT_W
ack_err  out  1  sticky: controller failed to acknowledge start

Behaviour:
- Reset (async, rst_n=0): FIFO empty, state IDLE, cur=0, start=0, done=0, retired=0, ack_err=0, in_ready=1. Reset mid-operation abandons the current instruction with no done pulse.
- Push: in_valid & in_ready at a posedge writes in_instr. Push while full is refused; no bypass when full, even if a pop occurs the same cycle. Push into empty FIFO becomes poppable the next cycle (no empty bypass).
- flush: at posedge clears FIFO pointers. A push in the same cycle is discarded. cur and state are unaffected.
- FSM:
  - IDLE: start=0. If FIFO non-empty & waiting=1 & !flush: cur<=head, pop, -> ISSUE.
  - ISSUE: start=1 (exactly one cycle), ackcnt<=0, -> ACK.
  - ACK: start=0. If waiting=0 -> EXEC. Else ackcnt++. When ackcnt==ACK_TIMEOUT-1 with waiting still 1: ack_err<=1, -> IDLE (instruction dropped, no done, retired unchanged).
  - EXEC: if waiting=1: done=1 for that cycle, retired++, -> IDLE.
- Fields and cur_instr are driven from cur register only. They change only on the IDLE->ISSUE edge, so they are stable from start through retirement.
- Best-case latency:
  - Push at edge N; pop/load at edge N+1.
  - start high between edges N+1 and N+2.
  - Controller samples start at edge N+2.
- Back-to-back: the next issue requires one IDLE cycle after done. done and the next start are never in the same cycle.
- ack_err clears only on reset.

Decomposition:
- Package instr_issuer_pkg:
  - state enum {IDLE, ISSUE, ACK, EXEC}
  - field slice constants OP_HI=15, OP_LO=13, ALU_HI=12, ALU_LO=11, SH_HI=4, SH_LO=3
- Sub-module issue_fifo (DEPTH, width 16; push, pop, flush, full, empty, head; extra pointer bit for full/empty).
- FSM, counters and holding register stay in instr_issuer.

Test Plan:
- Reset, push 16'hA0E0 at cycle 1, controller model waiting=1, drops 1 cycle after start, rises 5 cycles later -> start one cycle at cycle 2; opcode=3'b101, ALU_op=2'b00, shift_op=2'b00 held through EXEC; done once; retired=1.
- Push 5 instructions with no pops, DEPTH=4 -> in_ready=0 after 4th; 5th refused; after first pop in_ready=1 the next cycle.
- Waiting held at 1 after start (ACK_TIMEOUT=8) -> ack_err=1 eight cycles after start pulse; done never pulses; retired unchanged; next queued instruction issues afterwards.
- Queue 3 instructions, assert flush during EXEC of first -> first retires normally (retired+1); FIFO empty; no further start.
- Drop rst_n mid-EXEC -> start=0, busy=0, retired=0, in_ready=1 immediately (async); no done.
- 256 instructions retired with CNT_W=8 -> retired wraps to 0 on the 256th done.
